// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush squash and bubble counter
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_opcode,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic             id_jalr_jump,
  input  logic             id_jal_jump,
  input  logic [1:0]       id_regwrite_sel,
  input  logic [2:0]       id_aluop,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic             ex_jalr_jump,
  output logic             ex_jal_jump,
  output logic [1:0]       ex_regwrite_sel,
  output logic [2:0]       ex_aluop,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jalr_jump;
    logic       jal_jump;
    logic [1:0] regwrite_sel;
    logic [2:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } data_t;

  ctrl_t            id_ctrl, ctrl_d, ctrl_q;
  data_t            id_data, data_d, data_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rs1_used, rs2_used, hazard, load_bubble;

  assign id_ctrl = {id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
                    id_jalr_jump, id_jal_jump, id_regwrite_sel, id_aluop};
  assign id_data = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                    id_funct3, id_funct7b5};

  // Hazard is evaluated against what EX holds right now, so it clears on its own once a bubble lands.
  always_comb begin
    rs1_used = (id_opcode != OP_LUI) && (id_opcode != OP_AUIPC) && (id_opcode != OP_JAL);
    rs2_used = (id_opcode == OP_R) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
    hazard   = valid_q && ctrl_q.memread && (data_q.rd != 5'd0) && id_valid &&
               ((rs1_used && (id_rs1 == data_q.rd)) || (rs2_used && (id_rs2 == data_q.rd)));
    stall       = hazard && !flush;
    load_bubble = flush || (en && hazard);
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = id_data;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (en) begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : '0;
      data_d  = id_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid        = valid_q;
  assign ex_branch       = ctrl_q.branch;
  assign ex_memread      = ctrl_q.memread;
  assign ex_memtoreg     = ctrl_q.memtoreg;
  assign ex_memwrite     = ctrl_q.memwrite;
  assign ex_alusrc       = ctrl_q.alusrc;
  assign ex_regwrite     = ctrl_q.regwrite;
  assign ex_jalr_jump    = ctrl_q.jalr_jump;
  assign ex_jal_jump     = ctrl_q.jal_jump;
  assign ex_regwrite_sel = ctrl_q.regwrite_sel;
  assign ex_aluop        = ctrl_q.aluop;
  assign ex_pc           = data_q.pc;
  assign ex_rs1_data     = data_q.rs1_data;
  assign ex_rs2_data     = data_q.rs2_data;
  assign ex_imm          = data_q.imm;
  assign ex_rs1          = data_q.rs1;
  assign ex_rs2          = data_q.rs2;
  assign ex_rd           = data_q.rd;
  assign ex_funct3       = data_q.funct3;
  assign ex_funct7b5     = data_q.funct7b5;
  assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_IMM = 5'b00100, OP_R = 5'b01100;
  localparam logic [4:0] OP_S = 5'b01000, OP_B = 5'b11000, OP_LUI = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101, OP_JAL = 5'b11011, OP_JALR = 5'b11001;

  logic clk = 1'b0, rst, en, flush, id_valid;
  logic [4:0] id_opcode, id_rs1, id_rs2, id_rd;
  logic id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic id_jalr_jump, id_jal_jump, id_funct7b5;
  logic [1:0] id_regwrite_sel;
  logic [2:0] id_aluop, id_funct3;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic ex_jalr_jump, ex_jal_jump, ex_funct7b5, stall;
  logic [1:0] ex_regwrite_sel;
  logic [2:0] ex_aluop, ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0] bubble_cnt;

  int n_checks = 0, n_pass = 0;

  logic [12:0]  id_ctrl_v, ex_ctrl_v;
  logic [146:0] id_data_v, ex_data_v;
  assign id_ctrl_v = {id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
                      id_jalr_jump, id_jal_jump, id_regwrite_sel, id_aluop};
  assign ex_ctrl_v = {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
                      ex_jalr_jump, ex_jal_jump, ex_regwrite_sel, ex_aluop};
  assign id_data_v = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5};
  assign ex_data_v = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5};

  // Reference view of the EX slot: what instruction it holds, not how the RTL stores it.
  logic         m_valid, m_memread, m_known;
  logic [4:0]   m_rd;
  logic [12:0]  m_ctrl;
  logic [146:0] m_data;
  int           m_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_jalr_jump(id_jalr_jump), .id_jal_jump(id_jal_jump), .id_regwrite_sel(id_regwrite_sel),
    .id_aluop(id_aluop), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_jalr_jump(ex_jalr_jump),
    .ex_jal_jump(ex_jal_jump), .ex_regwrite_sel(ex_regwrite_sel), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_hazard();
    bit r1, r2;
    r1 = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC || id_opcode == OP_JAL);
    r2 = (id_opcode == OP_R || id_opcode == OP_S || id_opcode == OP_B);
    return m_valid && m_memread && m_rd != 0 && id_valid &&
           ((r1 && id_rs1 == m_rd) || (r2 && id_rs2 == m_rd));
  endfunction

  function automatic void model_bubble();
    m_valid = 0; m_memread = 0; m_ctrl = '0; m_known = 0;
    if (m_cnt < 15) m_cnt++;
  endfunction

  function automatic void model_edge();
    if (flush) model_bubble();
    else if (!en) begin end
    else if (model_hazard()) model_bubble();
    else begin
      m_valid = id_valid; m_known = 1; m_data = id_data_v; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl_v : '0; m_memread = id_valid & id_memread;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    logic [4:0] ops [9];
    ops = '{OP_LOAD, OP_IMM, OP_R, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    id_valid = ($urandom_range(0, 7) != 0);
    id_opcode = ops[$urandom_range(0, 8)];
    {id_branch, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_jalr_jump, id_jal_jump} = 7'($urandom);
    id_memread = $urandom_range(0, 1) == 1;
    id_regwrite_sel = 2'($urandom); id_aluop = 3'($urandom);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
    id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic mr);
    rand_inputs();
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_memread = mr; id_memtoreg = mr; id_regwrite = 1'b1; id_alusrc = (op != OP_R);
    id_branch = 0; id_memwrite = 0; id_jalr_jump = 0; id_jal_jump = 0;
    id_regwrite_sel = mr ? 2'b01 : 2'b00; id_aluop = 3'b010;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0;
    set_instr(1, OP_R, 5'd5, 5'd1, 5'd2, 0);
    #12;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (ex_ctrl_v !== 13'd0) $display("FAIL reset_ctrl got %h want 0", ex_ctrl_v); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", bubble_cnt); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_passthrough();
    set_instr(1, OP_R, 5'd5, 5'd1, 5'd2, 0);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL pass_stall_pre got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_rd !== 5'd5) $display("FAIL pass_rd got %0d want 5", ex_rd); else n_pass++;
    n_checks++; if (ex_regwrite !== 1'b1) $display("FAIL pass_regwrite got %b want 1", ex_regwrite); else n_pass++;
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", ex_valid); else n_pass++;
    n_checks++; if (ex_aluop !== 3'b010) $display("FAIL pass_aluop got %b want 010", ex_aluop); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL pass_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd0) $display("FAIL pass_cnt got %0d want 0", bubble_cnt); else n_pass++;
  endtask

  task automatic test_load_use();
    set_instr(1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_R, 5'd7, 5'd6, 5'd1, 0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (ex_ctrl_v !== 13'd0) $display("FAIL lu_bubble_ctrl got %h want 0", ex_ctrl_v); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd1) $display("FAIL lu_cnt got %0d want 1", bubble_cnt); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_stall_after got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) $display("FAIL lu_add_in_ex got v=%b rd=%0d want v=1 rd=7", ex_valid, ex_rd); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_stall_final got %b want 0", stall); else n_pass++;
  endtask

  task automatic test_no_false_hazard();
    set_instr(1, OP_LOAD, 5'd0, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_R, 5'd1, 5'd0, 5'd0, 0);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfh_x0 got %b want 0", stall); else n_pass++;
    set_instr(1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_LUI, 5'd6, 5'd6, 5'd6, 0);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfh_lui got %b want 0", stall); else n_pass++;
    set_instr(1, OP_IMM, 5'd7, 5'd8, 5'd6, 0);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfh_rs2_unused got %b want 0", stall); else n_pass++;
    set_instr(1, OP_S, 5'd0, 5'd8, 5'd6, 0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL nfh_store_rs2 got %b want 1", stall); else n_pass++;
    id_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfh_invalid_id got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl_v !== 13'd0) $display("FAIL nfh_invalid_adv got v=%b ctrl=%h want 0", ex_valid, ex_ctrl_v); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd1) $display("FAIL nfh_cnt got %0d want 1", bubble_cnt); else n_pass++;
  endtask

  task automatic test_flush_vs_hazard();
    set_instr(1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_R, 5'd7, 5'd6, 5'd1, 0);
    flush = 1'b1; en = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL fvh_stall got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl_v !== 13'd0) $display("FAIL fvh_bubble got v=%b ctrl=%h want 0", ex_valid, ex_ctrl_v); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd2) $display("FAIL fvh_cnt got %0d want 2", bubble_cnt); else n_pass++;
    flush = 1'b0; en = 1'b1;
  endtask

  task automatic test_hold();
    set_instr(1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_R, 5'd7, 5'd6, 5'd1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1) $display("FAIL hold_stall[%0d] got %b want 1", i, stall); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_memread !== 1'b1) $display("FAIL hold_ex[%0d] got v=%b rd=%0d mr=%b want 1/6/1", i, ex_valid, ex_rd, ex_memread); else n_pass++;
      n_checks++; if (bubble_cnt !== 4'd2) $display("FAIL hold_cnt[%0d] got %0d want 2", i, bubble_cnt); else n_pass++;
    end
    en = 1'b1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || bubble_cnt !== 4'd3) $display("FAIL hold_release got v=%b cnt=%0d want 0/3", ex_valid, bubble_cnt); else n_pass++;
  endtask

  task automatic test_random();
    rst = 1'b0; #1; rst = 1'b1;
    m_valid = 0; m_memread = 0; m_known = 0; m_rd = 0; m_ctrl = '0; m_data = '0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      flush = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 7) != 0);
      #1;
      n_checks++; if (stall !== (model_hazard() && !flush)) $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, model_hazard() && !flush); else n_pass++;
      @(posedge clk);
      model_edge();
      #1;
      n_checks++; if (ex_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", i, ex_valid, m_valid); else n_pass++;
      n_checks++; if (ex_ctrl_v !== m_ctrl) $display("FAIL rnd_ctrl[%0d] got %h want %h", i, ex_ctrl_v, m_ctrl); else n_pass++;
      n_checks++; if (int'(bubble_cnt) != m_cnt) $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, bubble_cnt, m_cnt); else n_pass++;
      if (m_known) begin
        n_checks++; if (ex_data_v !== m_data) $display("FAIL rnd_data[%0d] got %h want %h", i, ex_data_v, m_data); else n_pass++;
      end
    end
    flush = 1'b0; en = 1'b1;
  endtask

  task automatic test_saturation_reset();
    rst = 1'b0; #1; rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      rand_inputs();
      flush = 1'b1; en = $urandom_range(0, 1) == 1;
      tick();
      if (i == 10) begin
        n_checks++; if (bubble_cnt !== 4'd10) $display("FAIL sat_cnt10 got %0d want 10", bubble_cnt); else n_pass++;
      end
    end
    n_checks++; if (bubble_cnt !== 4'd15) $display("FAIL sat_cnt20 got %0d want 15", bubble_cnt); else n_pass++;
    flush = 1'b0; en = 1'b1;
    set_instr(1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1);
    tick();
    set_instr(1, OP_R, 5'd7, 5'd6, 5'd1, 0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL rst_pre_stall got %b want 1", stall); else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0 || ex_ctrl_v !== 13'd0) $display("FAIL rst_ex got v=%b ctrl=%h want 0", ex_valid, ex_ctrl_v); else n_pass++;
    n_checks++; if (ex_data_v !== 147'd0) $display("FAIL rst_data got %h want 0", ex_data_v); else n_pass++;
    n_checks++; if (bubble_cnt !== 4'd0) $display("FAIL rst_cnt got %0d want 0", bubble_cnt); else n_pass++;
    tick();
    rst = 1'b1;
    id_valid = 1'b0;
    tick();
    n_checks++; if (bubble_cnt !== 4'd0 || ex_valid !== 1'b0) $display("FAIL rst_after got cnt=%0d v=%b want 0/0", bubble_cnt, ex_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_hazard();
    test_flush_vs_hazard();
    test_hold();
    test_random();
    test_saturation_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
